// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared op codes, state encoding and counter width for the mul/div sequencer
package muldiv_ctrl_pkg;
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;
    typedef enum logic {S_IDLE, S_BUSY} md_state_e;
    localparam int CNT_W = 4;
endpackage

// File: rtl/muldiv_ctrl_alu.sv
// muldiv_ctrl_alu: combinational mult/multu/div/divu producing next HI/LO and a divide-by-zero flag
module muldiv_ctrl_alu
    import muldiv_ctrl_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_divz
);
    logic        w_sa, w_sb;
    logic [31:0] w_mag_a, w_mag_b, w_div_b, w_q, w_r;
    logic [63:0] w_ps, w_pu;
    // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing
    assign w_sa    = (i_op == OP_DIV) & i_a[31];
    assign w_sb    = (i_op == OP_DIV) & i_b[31];
    assign w_mag_a = w_sa ? -i_a : i_a;
    assign w_mag_b = w_sb ? -i_b : i_b;
    assign w_div_b = (i_b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_q     = w_mag_a / w_div_b;
    assign w_r     = w_mag_a % w_div_b;
    assign w_ps    = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_pu    = {32'd0, i_a} * {32'd0, i_b};
    assign {o_hi, o_lo} = (i_op == OP_MULT)  ? w_ps :
                          (i_op == OP_MULTU) ? w_pu :
                          {(w_sa ? -w_r : w_r), ((w_sa ^ w_sb) ? -w_q : w_q)};
    assign o_divz = ((i_op == OP_DIV) | (i_op == OP_DIVU)) & (i_b == 32'd0);
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: fixed-latency mul/div sequencer owning HI/LO, with busy and D-stage stall request
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    md_state_e          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_pend_hi, r_pend_lo, r_hi, r_lo;
    logic               r_divz;
    logic [31:0]        w_hi_n, w_lo_n;
    logic               w_divz, w_long;

    muldiv_ctrl_alu u_alu (
        .i_op   (op),
        .i_a    (src_a),
        .i_b    (src_b),
        .o_hi   (w_hi_n),
        .o_lo   (w_lo_n),
        .o_divz (w_divz)
    );

    assign w_long = start & (op <= OP_DIVU);
    assign busy   = (r_state == S_BUSY);
    assign stall  = md_use_d & (busy | w_long);
    assign hi     = r_hi;
    assign lo     = r_lo;

    // Result is held in pend regs and only committed to HI/LO on the final busy edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_divz    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_long) begin
                r_state   <= S_BUSY;
                r_cnt     <= (op <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                r_pend_hi <= w_hi_n;
                r_pend_lo <= w_lo_n;
                r_divz    <= w_divz;
            end else if (start && op == OP_MTHI) begin
                r_hi <= src_a;
            end else if (start && op == OP_MTLO) begin
                r_lo <= src_a;
            end
        end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                r_state <= S_IDLE;
                if (!r_divz) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end
        end
    end
endmodule
